hazard_ctrl: RTL and testbench

- Central pipeline controller for the five-stage core (F, D, E/ALU, C/cache, WB).
- Generates the operand-forwarding selects consumed by the ALU stage.
- Generates per-stage stall and flush for load-use hazards, branch/jump redirects and I/D-cache misses.
- Holds a small miss-sequencing FSM and two saturating performance counters.

---
 rtl/brisc_pkg.sv | 8 +
 rtl/fwd_unit.sv | 16 +
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared core widths and pipeline enums.
package brisc_pkg;
    localparam int REG_BITS = 5;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {RES_ALU, RES_CACHE, RES_PC4} result_src_e;
    typedef enum logic [1:0] {FROM_RF, FROM_CACHE, FROM_WB} fwd_src_e;
    typedef enum logic [1:0] {RUN, DMISS, IMISS} hz_state_e;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: picks the youngest in-flight producer of one ALU operand; C beats WB.
module fwd_unit
    import brisc_pkg::*;
(
    input  logic [REG_BITS-1:0] rs_E,
    input  logic [REG_BITS-1:0] rd_C,
    input  logic                reg_write_C,
    input  logic [REG_BITS-1:0] rd_WB,
    input  logic                reg_write_WB,
    output fwd_src_e            fwd_src
);
    always_comb begin
        fwd_src = (reg_write_C && rd_C != '0 && rd_C == rs_E) ? FROM_CACHE :
                  (reg_write_WB && rd_WB != '0 && rd_WB == rs_E) ? FROM_WB : FROM_RF;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stall/flush priority, miss FSM and perf counters.
module hazard_ctrl
    import brisc_pkg::*;
#(
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] rs1_D_in,
    input  logic [REG_BITS-1:0] rs2_D_in,
    input  logic [REG_BITS-1:0] rs1_E_in,
    input  logic [REG_BITS-1:0] rs2_E_in,
    input  logic [REG_BITS-1:0] rd_E_in,
    input  result_src_e         result_src_E_in,
    input  logic [REG_BITS-1:0] rd_C_in,
    input  logic                reg_write_C_in,
    input  logic [REG_BITS-1:0] rd_WB_in,
    input  logic                reg_write_WB_in,
    input  logic                redirect_E_in,
    input  logic                icache_miss_in,
    input  logic                icache_ready_in,
    input  logic                dcache_miss_in,
    input  logic                dcache_ready_in,
    output fwd_src_e            fwd_src1_E_out,
    output fwd_src_e            fwd_src2_E_out,
    output logic                stall_F_out,
    output logic                stall_D_out,
    output logic                stall_E_out,
    output logic                stall_C_out,
    output logic                flush_D_out,
    output logic                flush_E_out,
    output logic                flush_C_out,
    output hz_state_e           state_out,
    output logic [CNT_BITS-1:0] stall_cycles_out,
    output logic [CNT_BITS-1:0] redirects_out
);
    hz_state_e state_n;
    fwd_src_e  fwd1, fwd2;
    logic      pend_redirect;
    logic      load_use, dmiss, imiss, redir, lu, im, discard;
    fwd_unit u_fwd1 (.rs_E(rs1_E_in), .rd_C(rd_C_in), .reg_write_C(reg_write_C_in),
                     .rd_WB(rd_WB_in), .reg_write_WB(reg_write_WB_in), .fwd_src(fwd1));
    fwd_unit u_fwd2 (.rs_E(rs2_E_in), .rd_C(rd_C_in), .reg_write_C(reg_write_C_in),
                     .rd_WB(rd_WB_in), .reg_write_WB(reg_write_WB_in), .fwd_src(fwd2));
    always_comb begin
        load_use = result_src_E_in == RES_CACHE && rd_E_in != '0 &&
                   (rd_E_in == rs1_D_in || rd_E_in == rs2_D_in);
        dmiss    = dcache_miss_in || (state_out == DMISS && !dcache_ready_in);
        imiss    = icache_miss_in || (state_out == IMISS && !icache_ready_in);
        redir    = redirect_E_in && !dmiss;
        lu       = load_use && !dmiss && !redirect_E_in;
        im       = imiss && !dmiss && !redirect_E_in && !load_use;
        // a refill that raced a redirect fetched the wrong path and must be dropped
        discard  = state_out == IMISS && icache_ready_in && pend_redirect && !dmiss;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_out        <= RUN;
            pend_redirect    <= 1'b0;
            stall_cycles_out <= '0;
            redirects_out    <= '0;
        end else begin
            state_out     <= state_n;
            pend_redirect <= (redir && imiss) ? 1'b1 : discard ? 1'b0 : pend_redirect;
            if (stall_F_out && !(&stall_cycles_out))
                stall_cycles_out <= stall_cycles_out + 1'b1;
            if (redir && !(&redirects_out))
                redirects_out <= redirects_out + 1'b1;
        end
    end
    always_comb begin
        state_n = dmiss ? DMISS : imiss ? IMISS : RUN;
    end
    always_comb begin
        fwd_src1_E_out = reset ? FROM_RF : fwd1;
        fwd_src2_E_out = reset ? FROM_RF : fwd2;
        stall_F_out    = !reset && (dmiss || lu || im);
        stall_D_out    = !reset && (dmiss || lu);
        stall_E_out    = !reset && dmiss;
        stall_C_out    = !reset && dmiss;
        flush_D_out    = reset || redir || im || discard;
        flush_E_out    = reset || redir || lu;
        flush_C_out    = reset;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations for hazard_ctrl.
module tb_hazard_ctrl;
    import brisc_pkg::*;
    logic clk = 0, reset;
    logic [REG_BITS-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_C, rd_WB;
    result_src_e result_src_E;
    logic reg_write_C, reg_write_WB, redirect_E, icache_miss, icache_ready, dcache_miss, dcache_ready;
    fwd_src_e fwd1, fwd2;
    logic stall_F, stall_D, stall_E, stall_C, flush_D, flush_E, flush_C;
    hz_state_e state;
    logic [3:0] stall_cycles, redirects;
    int n_cmp = 0, n_bad = 0;

    hazard_ctrl #(.CNT_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .rs1_D_in(rs1_D), .rs2_D_in(rs2_D), .rs1_E_in(rs1_E), .rs2_E_in(rs2_E),
        .rd_E_in(rd_E), .result_src_E_in(result_src_E),
        .rd_C_in(rd_C), .reg_write_C_in(reg_write_C), .rd_WB_in(rd_WB), .reg_write_WB_in(reg_write_WB),
        .redirect_E_in(redirect_E), .icache_miss_in(icache_miss), .icache_ready_in(icache_ready),
        .dcache_miss_in(dcache_miss), .dcache_ready_in(dcache_ready),
        .fwd_src1_E_out(fwd1), .fwd_src2_E_out(fwd2),
        .stall_F_out(stall_F), .stall_D_out(stall_D), .stall_E_out(stall_E), .stall_C_out(stall_C),
        .flush_D_out(flush_D), .flush_E_out(flush_E), .flush_C_out(flush_C),
        .state_out(state), .stall_cycles_out(stall_cycles), .redirects_out(redirects)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_C, rd_WB} = '0;
        result_src_E = RES_ALU;
        {reg_write_C, reg_write_WB, redirect_E, icache_miss, icache_ready, dcache_miss, dcache_ready} = '0;
    endtask

    initial begin
        reset = 1;
        idle();
        reg_write_C = 1; rd_C = 5; rs1_E = 5; rs2_E = 5;
        tick();
        chk("rst_fwd1", fwd1, FROM_RF);
        chk("rst_fwd2", fwd2, FROM_RF);
        chk("rst_stall_F", stall_F, 0);
        chk("rst_stall_C", stall_C, 0);
        chk("rst_flush_D", flush_D, 1);
        chk("rst_flush_E", flush_E, 1);
        chk("rst_flush_C", flush_C, 1);
        tick();
        reset = 0; idle(); #1;
        chk("run_state", state, RUN);
        chk("run_stall_cnt", stall_cycles, 0);
        chk("run_redir_cnt", redirects, 0);
        chk("run_flush_C", flush_C, 0);
        // forwarding
        reg_write_C = 1; rd_C = 5; reg_write_WB = 1; rd_WB = 5; rs1_E = 5; rs2_E = 6; #1;
        chk("fwd_c_beats_wb", fwd1, FROM_CACHE);
        chk("fwd2_none", fwd2, FROM_RF);
        rd_WB = 6; #1;
        chk("fwd1_cache", fwd1, FROM_CACHE);
        chk("fwd2_wb", fwd2, FROM_WB);
        reg_write_C = 0; rd_WB = 5; rs2_E = 5; #1;
        chk("fwd1_wb", fwd1, FROM_WB);
        reg_write_WB = 0; #1;
        chk("fwd2_no_we", fwd2, FROM_RF);
        reg_write_C = 1; reg_write_WB = 1; rd_C = 0; rd_WB = 0; rs1_E = 0; #1;
        chk("fwd_x0", fwd1, FROM_RF);
        chk("no_stall_fwd", stall_F, 0);
        // load-use
        idle(); result_src_E = RES_CACHE; rd_E = 0; rs1_D = 0; #1;
        chk("lu_x0_nostall", stall_F, 0);
        rd_E = 7; rs2_D = 7; #1;
        chk("lu_stall_F", stall_F, 1);
        chk("lu_stall_D", stall_D, 1);
        chk("lu_flush_E", flush_E, 1);
        chk("lu_stall_E", stall_E, 0);
        chk("lu_flush_D", flush_D, 0);
        tick();
        idle(); #1;
        chk("lu_done", stall_F, 0);
        chk("lu_flush_E_off", flush_E, 0);
        chk("lu_cnt", stall_cycles, 1);
        // D-miss with a redirect held in E
        dcache_miss = 1; redirect_E = 1; #1;
        chk("dm0_stall_F", stall_F, 1);
        chk("dm0_stall_E", stall_E, 1);
        chk("dm0_stall_C", stall_C, 1);
        chk("dm0_flush_C", flush_C, 0);
        chk("dm0_flush_D", flush_D, 0);
        tick();
        dcache_miss = 0;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("dm_state", state, DMISS);
            chk("dm_stall_C", stall_C, 1);
            chk("dm_redir_cnt", redirects, 0);
            tick();
        end
        dcache_ready = 1; #1;
        chk("dm_ready_stall_F", stall_F, 0);
        chk("dm_ready_flush_E", flush_E, 1);
        chk("dm_ready_flush_D", flush_D, 1);
        tick();
        dcache_ready = 0; redirect_E = 0; #1;
        chk("dm_end_state", state, RUN);
        chk("dm_redir_cnt1", redirects, 1);
        chk("dm_stall_cnt", stall_cycles, 5);
        // I-miss with a redirect during refill
        icache_miss = 1; #1;
        chk("im0_stall_F", stall_F, 1);
        chk("im0_stall_D", stall_D, 0);
        chk("im0_flush_D", flush_D, 1);
        tick();
        icache_miss = 0; #1;
        chk("im1_state", state, IMISS);
        chk("im1_stall_F", stall_F, 1);
        tick();
        redirect_E = 1; #1;
        chk("im2_flush_D", flush_D, 1);
        chk("im2_flush_E", flush_E, 1);
        chk("im2_stall_F", stall_F, 0);
        tick();
        redirect_E = 0; #1;
        chk("im3_redir_cnt", redirects, 2);
        chk("im3_state", state, IMISS);
        chk("im3_stall_F", stall_F, 1);
        tick(); #1;
        chk("im4_stall_F", stall_F, 1);
        tick();
        icache_ready = 1; #1;
        chk("im5_stall_F", stall_F, 0);
        chk("im5_discard", flush_D, 1);
        tick();
        icache_ready = 0; #1;
        chk("im_end_state", state, RUN);
        chk("im_end_flush_D", flush_D, 0);
        chk("im_stall_cnt", stall_cycles, 9);
        // short I-miss: pend_redirect must already be clear
        icache_miss = 1; #1;
        tick();
        icache_miss = 0; icache_ready = 1; #1;
        chk("im_short_no_discard", flush_D, 0);
        chk("im_short_stall_F", stall_F, 0);
        tick();
        icache_ready = 0; #1;
        chk("im_short_cnt", stall_cycles, 10);
        // simultaneous D- and I-miss
        dcache_miss = 1; icache_miss = 1; #1;
        chk("both0_stall_F", stall_F, 1);
        chk("both0_stall_C", stall_C, 1);
        tick();
        dcache_miss = 0;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("both_dm_state", state, DMISS);
            chk("both_dm_stall_F", stall_F, 1);
            tick();
        end
        dcache_ready = 1; #1;
        chk("both3_stall_F", stall_F, 1);
        chk("both3_stall_C", stall_C, 0);
        chk("both3_flush_D", flush_D, 1);
        tick();
        dcache_ready = 0; icache_miss = 0; #1;
        chk("both4_state", state, IMISS);
        chk("both4_stall_F", stall_F, 1);
        tick();
        icache_ready = 1; #1;
        chk("both5_stall_F", stall_F, 0);
        tick();
        icache_ready = 0; #1;
        chk("both_end_state", state, RUN);
        chk("both_stall_cnt", stall_cycles, 15);
        // saturation
        result_src_E = RES_CACHE; rd_E = 3; rs1_D = 3; #1;
        chk("sat_stall_F", stall_F, 1);
        tick();
        idle(); #1;
        chk("sat_cnt", stall_cycles, 15);
        // reset during D-miss
        dcache_miss = 1; #1;
        tick();
        dcache_miss = 0; #1;
        chk("rdm_state", state, DMISS);
        chk("rdm_stall_C", stall_C, 1);
        reset = 1; #1;
        chk("rdm_rst_stall_C", stall_C, 0);
        chk("rdm_rst_stall_F", stall_F, 0);
        chk("rdm_rst_flush_C", flush_C, 1);
        tick();
        chk("rdm_state_run", state, RUN);
        chk("rdm_stall_cnt", stall_cycles, 0);
        chk("rdm_redir_cnt", redirects, 0);
        chk("rdm_flush_D", flush_D, 1);
        chk("rdm_flush_E", flush_E, 1);
        reset = 0;
        tick();
        chk("post_rst_state", state, RUN);
        chk("post_rst_stall_F", stall_F, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
